// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing the UART TX byte channel between two requesters,
// with a one-entry registered output stage. Define UART_ARB_LOCK_EN for packet lock.
module uart_tx_arb #(
  parameter int unsigned MAX_BURST = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  output logic       grant_vld,
  output logic       grant_id
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             grant_id_q, grant_id_d;
  logic             last_owner_q, last_owner_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             tx_valid_q;
  logic [7:0]       tx_data_q;

  logic       slot_free;
  logic       gnt_valid;
  logic [7:0] gnt_data;
  logic       gnt_last;
  logic       accept;
  logic       burst_hit;
  logic       release_now;

  // The output register can take a byte if it is empty or draining this cycle.
  assign slot_free = !tx_valid_q || tx_ready;
  assign gnt_valid = grant_id_q ? req1_valid : req0_valid;
  assign gnt_data  = grant_id_q ? req1_data  : req0_data;
  assign gnt_last  = grant_id_q ? req1_last  : req0_last;
  assign accept    = (state_q == GRANT) && gnt_valid && slot_free;
  assign burst_hit = (burst_cnt_q == CNT_W'(MAX_BURST - 1));

`ifdef UART_ARB_LOCK_EN
  assign release_now = accept && (gnt_last || burst_hit);
`else
  // Byte-level round robin: every accepted byte ends the grant.
  assign release_now = accept;
  logic unused_lock;
  assign unused_lock = gnt_last ^ burst_hit;
`endif

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_owner_d = last_owner_q;
    burst_cnt_d  = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          state_d     = GRANT;
          burst_cnt_d = '0;
          if (req0_valid && req1_valid) grant_id_d = !last_owner_q;
          else                          grant_id_d = req1_valid;
        end
      end
      GRANT: begin
        if (accept) burst_cnt_d = burst_cnt_q + CNT_W'(1);
        if (release_now) begin
          state_d      = IDLE;
          last_owner_d = grant_id_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the same pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      grant_id_q   <= 1'b0;
      last_owner_q <= 1'b1;
      burst_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

  // A new byte and a drain in the same cycle keep tx_valid high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else if (accept) begin
      tx_valid_q <= 1'b1;
      tx_data_q  <= gnt_data;
    end else if (tx_ready) begin
      tx_valid_q <= 1'b0;
    end
  end

  assign grant_vld  = (state_q == GRANT);
  assign grant_id   = grant_id_q;
  assign req0_ready = grant_vld && !grant_id_q && slot_free;
  assign req1_ready = grant_vld &&  grant_id_q && slot_free;
  assign tx_valid   = tx_valid_q;
  assign tx_data    = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb (MAX_BURST=4): cycle vector table plus
// streaming sequences whose expected byte order depends on UART_ARB_LOCK_EN.
module tb_uart_tx_arb;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       req0_valid = 1'b0, req0_last = 1'b0, req0_ready;
  logic [7:0] req0_data = 8'h00;
  logic       req1_valid = 1'b0, req1_last = 1'b0, req1_ready;
  logic [7:0] req1_data = 8'h00;
  logic       tx_valid, tx_ready = 1'b0, grant_vld, grant_id;
  logic [7:0] tx_data;

  uart_tx_arb #(.MAX_BURST(4)) dut (
    .clk(clk), .rstn(rstn),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .grant_vld(grant_vld), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic       rstn;
    logic       r0v; logic [7:0] r0d; logic r0l;
    logic       r1v; logic [7:0] r1d; logic r1l;
    logic       txr;
    logic       e_r0rdy, e_r1rdy, e_txv; logic [7:0] e_txd; logic e_gv, e_gid;
  } vec_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } byte_t;

  byte_t      q0[$], q1[$];
  logic [7:0] got[$], exp_bytes[$];
  int         seg_id[$], seg_n[$], exp_seg_id[$], exp_seg_n[$];

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; tx_ready = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Drives both requesters from q0/q1 and records tx bytes and grant segments.
  task automatic run_stream(input string tag, input bit bp);
    int cyc = 0;
    int gap = 0;
    bit prev_gv = 1'b0;
    bit started = 1'b0;
    bit done = 1'b0;
    bit idle_in;
    while (!done && cyc < 400) begin
      @(negedge clk);
      idle_in = (q0.size() == 0) && (q1.size() == 0);
      req0_valid = (q0.size() != 0);
      req0_data  = req0_valid ? q0[0].data : 8'h00;
      req0_last  = req0_valid ? q0[0].last : 1'b0;
      req1_valid = (q1.size() != 0);
      req1_data  = req1_valid ? q1[0].data : 8'h00;
      req1_last  = req1_valid ? q1[0].last : 1'b0;
      tx_ready   = bp ? (cyc % 3 != 2) : 1'b1;
      #1;
      if (grant_vld) begin
        if (!prev_gv) begin
          if (started) check({tag, "_idle_gap"}, gap, 1);
          started = 1'b1;
          seg_id.push_back(int'(grant_id));
          seg_n.push_back(0);
        end
        gap = 0;
      end else begin
        gap++;
      end
      if (req0_valid && req0_ready) begin
        void'(q0.pop_front());
        if (seg_n.size() != 0) seg_n[seg_n.size()-1] += 1;
      end
      if (req1_valid && req1_ready) begin
        void'(q1.pop_front());
        if (seg_n.size() != 0) seg_n[seg_n.size()-1] += 1;
      end
      if (tx_valid && tx_ready) got.push_back(tx_data);
      prev_gv = grant_vld;
      done = idle_in && !tx_valid;
      cyc++;
    end
    check({tag, "_done"}, done, 1'b1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic compare_results(input string tag);
    check({tag, "_nbytes"}, got.size(), exp_bytes.size());
    for (int i = 0; i < got.size() && i < exp_bytes.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), got[i], exp_bytes[i]);
    check({tag, "_nsegs"}, seg_id.size(), exp_seg_id.size());
    for (int i = 0; i < seg_id.size() && i < exp_seg_id.size(); i++) begin
      check($sformatf("%s_seg%0d_id", tag, i), seg_id[i], exp_seg_id[i]);
      check($sformatf("%s_seg%0d_len", tag, i), seg_n[i], exp_seg_n[i]);
    end
    got.delete(); exp_bytes.delete();
    seg_id.delete(); seg_n.delete(); exp_seg_id.delete(); exp_seg_n.delete();
    q0.delete(); q1.delete();
  endtask

  // req0: 01,02,03(last)  req1: 11..14(last14)
  task automatic load_tie();
    for (int i = 1; i <= 3; i++) q0.push_back('{8'(i), i == 3});
    for (int i = 1; i <= 4; i++) q1.push_back('{8'(8'h10 + i), i == 4});
`ifdef UART_ARB_LOCK_EN
    exp_bytes = '{8'h01, 8'h02, 8'h03, 8'h11, 8'h12, 8'h13, 8'h14};
    exp_seg_id = '{0, 1};
    exp_seg_n  = '{3, 4};
`else
    exp_bytes = '{8'h01, 8'h11, 8'h02, 8'h12, 8'h03, 8'h13, 8'h14};
    exp_seg_id = '{0, 1, 0, 1, 0, 1, 1};
    exp_seg_n  = '{1, 1, 1, 1, 1, 1, 1};
`endif
  endtask

  vec_t vecs[18];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200us, expected to finish");
    $fatal(1);
  end

  initial begin
    //            rstn r0v r0d  r0l r1v r1d  r1l txr  r0rdy r1rdy txv txd  gv gid
    vecs[0]  = '{0, 1, 8'h41, 1, 1, 8'h77, 1, 1,  0, 0, 0, 8'h00, 0, 0};
    vecs[1]  = '{0, 1, 8'h41, 1, 1, 8'h77, 1, 1,  0, 0, 0, 8'h00, 0, 0};
    vecs[2]  = '{1, 1, 8'h41, 1, 0, 8'h00, 0, 1,  0, 0, 0, 8'h00, 0, 0};
    vecs[3]  = '{1, 1, 8'h41, 1, 0, 8'h00, 0, 1,  1, 0, 0, 8'h00, 1, 0};
    vecs[4]  = '{1, 0, 8'h00, 0, 0, 8'h00, 0, 0,  0, 0, 1, 8'h41, 0, 0};
    vecs[5]  = '{1, 0, 8'h00, 0, 1, 8'h52, 1, 0,  0, 0, 1, 8'h41, 0, 0};
    vecs[6]  = '{1, 0, 8'h00, 0, 1, 8'h52, 1, 0,  0, 0, 1, 8'h41, 1, 1};
    vecs[7]  = '{1, 0, 8'h00, 0, 1, 8'h52, 1, 0,  0, 0, 1, 8'h41, 1, 1};
    vecs[8]  = '{1, 0, 8'h00, 0, 1, 8'h52, 1, 1,  0, 1, 1, 8'h41, 1, 1};
    vecs[9]  = '{1, 0, 8'h00, 0, 0, 8'h00, 0, 0,  0, 0, 1, 8'h52, 0, 0};
    vecs[10] = '{1, 0, 8'h00, 0, 0, 8'h00, 0, 1,  0, 0, 1, 8'h52, 0, 0};
    vecs[11] = '{1, 0, 8'h00, 0, 0, 8'h00, 0, 0,  0, 0, 0, 8'h00, 0, 0};
    vecs[12] = '{1, 1, 8'h10, 1, 1, 8'h20, 1, 1,  0, 0, 0, 8'h00, 0, 0};
    vecs[13] = '{1, 1, 8'h10, 1, 1, 8'h20, 1, 1,  1, 0, 0, 8'h00, 1, 0};
    vecs[14] = '{1, 0, 8'h00, 0, 1, 8'h20, 1, 1,  0, 0, 1, 8'h10, 0, 0};
    vecs[15] = '{1, 0, 8'h00, 0, 1, 8'h20, 1, 1,  0, 1, 0, 8'h00, 1, 1};
    vecs[16] = '{1, 0, 8'h00, 0, 0, 8'h00, 0, 1,  0, 0, 1, 8'h20, 0, 0};
    vecs[17] = '{1, 0, 8'h00, 0, 0, 8'h00, 0, 1,  0, 0, 0, 8'h00, 0, 0};

    // Reset values, arbitration latency, backpressure and same-cycle refill.
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      rstn       = vecs[i].rstn;
      req0_valid = vecs[i].r0v; req0_data = vecs[i].r0d; req0_last = vecs[i].r0l;
      req1_valid = vecs[i].r1v; req1_data = vecs[i].r1d; req1_last = vecs[i].r1l;
      tx_ready   = vecs[i].txr;
      #1;
      check($sformatf("vec%0d_req0_ready", i), req0_ready, vecs[i].e_r0rdy);
      check($sformatf("vec%0d_req1_ready", i), req1_ready, vecs[i].e_r1rdy);
      check($sformatf("vec%0d_tx_valid", i), tx_valid, vecs[i].e_txv);
      check($sformatf("vec%0d_grant_vld", i), grant_vld, vecs[i].e_gv);
      if (vecs[i].e_txv || !vecs[i].rstn)
        check($sformatf("vec%0d_tx_data", i), tx_data, vecs[i].e_txd);
      if (vecs[i].e_gv || !vecs[i].rstn)
        check($sformatf("vec%0d_grant_id", i), grant_id, vecs[i].e_gid);
    end

    // Tie from reset: requester 0 wins first.
    do_reset();
    load_tie();
    run_stream("tie", 1'b0);
    compare_results("tie");

    // Burst limit: req0 streams 10 bytes without last, req1 sends a 2-byte packet.
    do_reset();
    for (int i = 1; i <= 10; i++) q0.push_back('{8'(i), 1'b0});
    q1.push_back('{8'h11, 1'b0});
    q1.push_back('{8'h12, 1'b1});
`ifdef UART_ARB_LOCK_EN
    exp_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h11, 8'h12,
                  8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
    exp_seg_id = '{0, 1, 0, 0};
    exp_seg_n  = '{4, 2, 4, 2};
`else
    exp_bytes = '{8'h01, 8'h11, 8'h02, 8'h12};
    for (int i = 3; i <= 10; i++) exp_bytes.push_back(8'(i));
    exp_seg_id = '{0, 1, 0, 1};
    exp_seg_n  = '{1, 1, 1, 1};
    for (int i = 0; i < 8; i++) begin
      exp_seg_id.push_back(0);
      exp_seg_n.push_back(1);
    end
`endif
    run_stream("burst", 1'b0);
    compare_results("burst");

    // Make requester 0 the last owner, then reset in the middle of a req1 packet.
    do_reset();
    q0.push_back('{8'h01, 1'b1});
    exp_bytes = '{8'h01};
    exp_seg_id = '{0};
    exp_seg_n  = '{1};
    run_stream("single", 1'b0);
    compare_results("single");

    @(negedge clk);
    req1_valid = 1'b1; req1_data = 8'h11; req1_last = 1'b0; tx_ready = 1'b0;
    #1 check("mid_c0_grant_vld", grant_vld, 1'b0);
    @(negedge clk);
    #1 check("mid_c1_grant_vld", grant_vld, 1'b1);
    check("mid_c1_grant_id", grant_id, 1'b1);
    check("mid_c1_req1_ready", req1_ready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #1 check("mid_c3_grant_vld", grant_vld, 1'b1);
    check("mid_c3_tx_valid", tx_valid, 1'b1);
    check("mid_c3_tx_data", tx_data, 8'h11);
    check("mid_c3_req1_ready", req1_ready, 1'b0);
    rstn = 1'b0;
    #1 check("mid_rst_grant_vld", grant_vld, 1'b0);
    check("mid_rst_tx_valid", tx_valid, 1'b0);
    check("mid_rst_tx_data", tx_data, 8'h00);
    check("mid_rst_req1_ready", req1_ready, 1'b0);
    check("mid_rst_req0_ready", req0_ready, 1'b0);
    @(negedge clk);
    rstn = 1'b1; req1_valid = 1'b0;

    // Tie order restored after reset, now with tx backpressure.
    load_tie();
    run_stream("tie_bp", 1'b1);
    compare_results("tie_bp");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Two-requester arbiter that shares the single UART transmit byte channel (tx_valid/tx_ready/tx_data into the uart core) between the AHB bridge and a second byte source (e.g. debug/trace). Round-robin grant, packet lock with a burst limit, and a one-entry registered output stage toward the uart core. It sits between the byte sources and the uart core's TX interface inside the UART subsystem.

## Interface
- MAX_BURST, 16: maximum bytes sent under one grant before a forced release; legal range 1..255.
- clk  input  1  system clock, all logic on rising edge.
- rstn  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 (AHB bridge) has a byte.
- req0_data  input  8  requester 0 byte.
- req0_last  input  1  byte is the last of requester 0's packet.
- req0_ready  output  1  requester 0 byte accepted when req0_valid & req0_ready.
- req1_valid / req1_data / req1_last / req1_ready: same as requester 0, for requester 1.
- tx_valid  output  1  byte available to uart core (registered).
- tx_data  output  8  byte to uart core (registered).
- tx_ready  input  1  uart core accepts byte when tx_valid & tx_ready.
- grant_vld  output  1  a grant is currently held.
- grant_id  output  1  index of granted requester (valid when grant_vld).

## Operation
- States: IDLE (no grant), GRANT (grant_id owns the channel).
- IDLE: if any reqN_valid, register grant next cycle. Both valid: pick requester != last_owner (last_owner resets to 1, so requester 0 wins first tie). One valid: pick it. Go GRANT, clear burst counter.
- GRANT: req_ready[grant_id] = !tx_valid | tx_ready; non-granted req_ready = 0. All req_ready = 0 in IDLE.
- Accept (granted valid & ready): tx_data <= byte, tx_valid <= 1, burst counter +1.
- tx_valid & tx_ready with no accept in same cycle: tx_valid <= 0. Both in same cycle: tx_valid stays 1, tx_data takes new byte.
- Release: on accept of a byte with reqN_last = 1, or of the MAX_BURST-th byte under this grant: last_owner <= grant_id, go IDLE next cycle. Output register is not flushed on release; pending byte drains normally.
- Burst counter width $clog2(MAX_BURST+1); never wraps (release occurs at MAX_BURST).
- Granted requester dropping valid mid-packet: grant held (waits), no timeout.
- Requester data/last must be held stable while valid & !ready.

## Timing
- Reset values: tx_valid 0, tx_data 8'h00, req0_ready 0, req1_ready 0, grant_vld 0, grant_id 0; state IDLE, last_owner 1, counter 0.
- Async reset mid-operation: all state to reset values immediately; byte in output register is lost.
- Arbitration latency: reqN_valid rising in IDLE at cycle 0 -> grant_vld = 1 and reqN_ready = 1 in cycle 1 -> tx_valid = 1 in cycle 2.
- Steady state with tx_ready = 1: one byte per cycle.
- Release to next grant: one IDLE cycle (req_ready 0 for both) before new grant.
- grant_vld/grant_id registered, change only on the edge after arbitration/release.

## Configuration
- UART_ARB_LOCK_EN defined: packet lock as above (release on last or MAX_BURST).
- Not defined: reqN_last ignored; grant released after every accepted byte (byte-level round robin, MAX_BURST unused); still one IDLE cycle between grants.

## Test plan
- Reset: hold rstn=0, drive both valid -> all outputs at reset values; release rstn, req0_valid=1 data 8'h41 -> req0_ready=1 in cycle 1, tx_valid=1 tx_data=8'h41 in cycle 2.
- Tie: both valid from IDLE, tx_ready=1, req0 sends 3 bytes (last on 3rd) -> req0 granted first, then 1 IDLE cycle, req1 granted; tx order 0,0,0,1....
- Burst limit: MAX_BURST=4, req0 sends 10 bytes no last, req1 valid -> after 4th req0 byte grant goes to req1; req0 resumes after req1's packet.
- Backpressure: tx_ready=0 with tx_valid=1 -> req_ready=0, tx_data stable; tx_ready=1 and new byte same cycle -> tx_valid stays 1, tx_data updates, no byte lost or duplicated.
- Mid-packet async reset: assert rstn=0 during req1 packet -> grant_vld=0, tx_valid=0 immediately; after release, req0-first tie behaviour restored.
- UART_ARB_LOCK_EN undefined: both valid, 4 bytes each -> tx alternates 0,1,0,1... with one IDLE cycle between bytes.
